// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline types: LSU operation encoding and the EX->MEM packet.
package riscv_pkg;

  localparam int XLEN = 64;

  typedef enum logic [3:0] {
    LSU_NONE = 4'd0,
    LSU_LB, LSU_LH, LSU_LW, LSU_LD, LSU_LBU, LSU_LHU, LSU_LWU,
    LSU_SB, LSU_SH, LSU_SW, LSU_SD
  } lsu_op_t;

  typedef struct packed {
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] store_data;
    logic [4:0]      rd_addr;
    logic            reg_write;
    lsu_op_t         lsu_op;
    logic            mem_write;
    logic            mem_to_reg;
  } ex_mem_pkt_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Payload-agnostic valid/ready buffer with synchronous flush.
// SKID=1: main + skid entry, registered in_ready; SKID=0: single entry, combinational in_ready.
module pipe_skid_buf #(
  parameter int WIDTH = 8,
  parameter bit SKID  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [1:0]       occupancy_o
);

  logic             m_valid_q, m_valid_d, s_valid_q, s_valid_d;
  logic [WIDTH-1:0] m_data_q, m_data_d, s_data_q, s_data_d;
  logic [1:0]       occ_q, occ_d;
  logic             in_fire, out_fire;

  assign in_ready_o  = SKID ? !s_valid_q : (!m_valid_q | out_ready_i);
  assign out_valid_o = m_valid_q;
  assign out_data_o  = m_data_q;
  assign occupancy_o = occ_q;
  assign in_fire     = in_valid_i & in_ready_o;
  assign out_fire    = m_valid_q & out_ready_i;

  always_comb begin
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    m_data_d  = m_data_q;
    s_data_d  = s_data_q;
    if (SKID && s_valid_q) begin
      // Skid entry drains into main before any new input is taken.
      if (out_fire) begin
        m_valid_d = 1'b1;
        m_data_d  = s_data_q;
        s_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      if (!m_valid_q || out_fire) begin
        m_valid_d = 1'b1;
        m_data_d  = in_data_i;
      end else if (SKID) begin
        s_valid_d = 1'b1;
        s_data_d  = in_data_i;
      end
    end else if (out_fire) begin
      m_valid_d = 1'b0;
    end
    // Payload is left in place so unqualified fields keep their last value.
    if (flush_i) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end
    occ_d = {1'b0, m_valid_d} + {1'b0, s_valid_d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      m_data_q  <= '0;
      s_data_q  <= '0;
      occ_q     <= 2'd0;
    end else begin
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
      m_data_q  <= m_data_d;
      s_data_q  <= s_data_d;
      occ_q     <= occ_d;
    end
  end

endmodule

// File: rtl/ex_mem_pipe_buf.sv
// EX->MEM elastic pipeline boundary: packs the EX result packet into a skid buffer
// and qualifies the control outputs with out_valid_o.
module ex_mem_pipe_buf #(
  parameter int XLEN = 64,
  parameter bit SKID = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [XLEN-1:0]     alu_result_i,
  input  logic [XLEN-1:0]     store_data_i,
  input  logic [4:0]          rd_addr_i,
  input  logic                reg_write_i,
  input  riscv_pkg::lsu_op_t  lsu_op_i,
  input  logic                mem_write_i,
  input  logic                mem_to_reg_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [XLEN-1:0]     alu_result_o,
  output logic [XLEN-1:0]     store_data_o,
  output logic [4:0]          rd_addr_o,
  output logic                reg_write_o,
  output riscv_pkg::lsu_op_t  lsu_op_o,
  output logic                mem_write_o,
  output logic                mem_to_reg_o,
  output logic [1:0]          occupancy_o
);
  import riscv_pkg::*;

  localparam int PKT_W = $bits(ex_mem_pkt_t);

  generate
    if (XLEN != riscv_pkg::XLEN) begin : g_bad_xlen
      $error("ex_mem_pipe_buf: XLEN parameter must match riscv_pkg::XLEN");
    end
  endgenerate

  ex_mem_pkt_t in_pkt, out_pkt;
  logic [PKT_W-1:0] out_bits;
  logic             out_valid;

  always_comb begin
    in_pkt            = '0;
    in_pkt.alu_result = alu_result_i;
    in_pkt.store_data = store_data_i;
    in_pkt.rd_addr    = rd_addr_i;
    in_pkt.reg_write  = reg_write_i;
    in_pkt.lsu_op     = lsu_op_i;
    in_pkt.mem_write  = mem_write_i;
    in_pkt.mem_to_reg = mem_to_reg_i;
  end

  pipe_skid_buf #(.WIDTH(PKT_W), .SKID(SKID)) u_buf (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_pkt),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_bits),
    .occupancy_o (occupancy_o)
  );

  assign out_pkt      = ex_mem_pkt_t'(out_bits);
  assign out_valid_o  = out_valid;
  assign alu_result_o = out_pkt.alu_result;
  assign store_data_o = out_pkt.store_data;
  assign rd_addr_o    = out_pkt.rd_addr;
  // Side-effecting controls must never leak from an empty slot.
  assign reg_write_o  = out_valid & out_pkt.reg_write;
  assign mem_write_o  = out_valid & out_pkt.mem_write;
  assign mem_to_reg_o = out_valid & out_pkt.mem_to_reg;
  assign lsu_op_o     = out_valid ? out_pkt.lsu_op : LSU_NONE;

endmodule
